// File: rtl/overlap_add_synth_pkg.sv
// Shared audio definitions for the overlap-add synthesis stage: default
// sample width, output-path FSM states and a generic signed saturator.
package overlap_add_synth_pkg;

  localparam int SAMPLE_WIDTH_DEF = 16;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    FLUSH  = 1'b1
  } ola_state_e;

  // Clamp a signed value to the range of a 'width'-bit signed integer.
  // Works on a 64-bit container so callers of any width can share it.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 32'd1));
    if (value > hi) begin
      sat_signed = hi;
    end else if (value < lo) begin
      sat_signed = lo;
    end else begin
      sat_signed = value;
    end
  endfunction

endpackage

// File: rtl/overlap_add_synth_sat_scale.sv
// Combinational arithmetic right shift followed by saturation from the
// accumulator width down to the output sample width.
module ola_sat_scale
  import overlap_add_synth_pkg::*;
#(
  parameter int ACC_W = 18,
  parameter int SW    = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [SW-1:0]    sample_o
);

  logic signed [ACC_W-1:0] shifted_s;
  logic signed [63:0]      wide_s;
  logic signed [63:0]      clamped_s;
  logic                    unused_hi_s;

  assign shifted_s   = acc_i >>> SHIFT;
  assign wide_s      = {{(64-ACC_W){shifted_s[ACC_W-1]}}, shifted_s};
  assign clamped_s   = sat_signed(wide_s, SW);
  assign sample_o    = clamped_s[SW-1:0];
  // Upper bits are pure sign extension after clamping.
  assign unused_hi_s = ^clamped_s[63:SW];

endmodule

// File: rtl/overlap_add_synth.sv
// Overlap-add synthesis: sums overlapping frames (FRAME_SIZE samples,
// advancing by HOP_SIZE) back into one continuous stream, with scaling and
// saturation on every completed sum and a flush mode that drains the tail.
module overlap_add_synth
  import overlap_add_synth_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int FRAME_SIZE   = 256,
  parameter int HOP_SIZE     = 128,
  parameter int OUT_SHIFT    = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [SAMPLE_WIDTH-1:0] in_sample,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  input  logic                           flush,
  output logic signed [SAMPLE_WIDTH-1:0] out_sample,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           frame_err
);

  localparam int ACC_W  = SAMPLE_WIDTH + $clog2(FRAME_SIZE / HOP_SIZE) + 1;
  localparam int PTR_W  = $clog2(FRAME_SIZE);
  localparam int PTR1_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]  HOP_P     = PTR_W'(HOP_SIZE);
  localparam logic [PTR_W-1:0]  LAST_K    = PTR_W'(FRAME_SIZE - 1);
  localparam logic [PTR_W-1:0]  TAIL_LAST = PTR_W'(FRAME_SIZE - HOP_SIZE - 1);
  localparam logic [PTR_W-1:0]  ONE_P     = PTR_W'(1);
  localparam logic [PTR1_W-1:0] FRAME_P   = PTR1_W'(FRAME_SIZE);

  // Modulo-FRAME_SIZE pointer addition (operands are already < FRAME_SIZE).
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W-1:0] b);
    logic [PTR1_W-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= FRAME_P) begin
      s = s - FRAME_P;
    end else begin
      s = s;
    end
    wrap_add = s[PTR_W-1:0];
  endfunction

  ola_state_e                     state_q, state_d;
  logic [PTR_W-1:0]               base_q, base_d;
  logic [PTR_W-1:0]               k_q, k_d;
  logic signed [ACC_W-1:0]        acc_q [FRAME_SIZE];
  logic signed [ACC_W-1:0]        acc_d [FRAME_SIZE];
  logic signed [SAMPLE_WIDTH-1:0] out_sample_q, out_sample_d;
  logic                           out_valid_q, out_valid_d;
  logic                           frame_err_q, frame_err_d;

  logic [PTR_W-1:0]               slot_s;
  logic signed [ACC_W-1:0]        cur_s;
  logic signed [ACC_W-1:0]        sext_s;
  logic signed [ACC_W-1:0]        sum_s;
  logic signed [ACC_W-1:0]        sat_in_s;
  logic signed [SAMPLE_WIDTH-1:0] sat_out_s;
  logic                           in_ready_s;
  logic                           flush_go_s;

  // In FLUSH, k_q doubles as the tail index j, so one slot address serves both modes.
  assign slot_s   = wrap_add(base_q, k_q);
  assign cur_s    = acc_q[slot_s];
  assign sext_s   = {{(ACC_W-SAMPLE_WIDTH){in_sample[SAMPLE_WIDTH-1]}}, in_sample};
  assign sum_s    = cur_s + sext_s;
  assign sat_in_s = (state_q == FLUSH) ? cur_s : sum_s;

  ola_sat_scale #(
    .ACC_W (ACC_W),
    .SW    (SAMPLE_WIDTH),
    .SHIFT (OUT_SHIFT)
  ) u_sat_scale (
    .acc_i    (sat_in_s),
    .sample_o (sat_out_s)
  );

  // Next-state logic: pointers, FSM, accumulator read-modify-write and output register.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    k_d          = k_q;
    acc_d        = acc_q;
    out_sample_d = out_sample_q;
    out_valid_d  = out_valid_q & ~out_ready;
    frame_err_d  = 1'b0;
    in_ready_s   = 1'b0;
    flush_go_s   = 1'b0;
    case (state_q)
      NORMAL: begin
        flush_go_s = flush & (k_q == '0) & ~out_valid_q;
        if (flush_go_s) begin
          state_d = FLUSH;
        end else begin
          // Completing samples need a free output register; tail samples do not.
          in_ready_s = (k_q >= HOP_P) | ~out_valid_q | out_ready;
          if (in_valid & in_ready_s) begin
            if (k_q < HOP_P) begin
              out_sample_d  = sat_out_s;
              out_valid_d   = 1'b1;
              acc_d[slot_s] = '0;
            end else begin
              acc_d[slot_s] = sum_s;
            end
            if ((k_q == LAST_K) | in_last) begin
              k_d    = '0;
              base_d = wrap_add(base_q, HOP_P);
            end else begin
              k_d = k_q + ONE_P;
            end
            frame_err_d = in_last ^ (k_q == LAST_K);
          end else begin
            frame_err_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (~out_valid_q | out_ready) begin
          out_sample_d  = sat_out_s;
          out_valid_d   = 1'b1;
          acc_d[slot_s] = '0;
          if (k_q == TAIL_LAST) begin
            k_d     = '0;
            base_d  = '0;
            state_d = NORMAL;
          end else begin
            k_d = k_q + ONE_P;
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        state_d = NORMAL;
      end
    endcase
  end

  // State registers with synchronous reset clearing every accumulator slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NORMAL;
      base_q       <= '0;
      k_q          <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < FRAME_SIZE; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      k_q          <= k_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      acc_q        <= acc_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q == FLUSH);
  assign frame_err  = frame_err_q;

endmodule
